// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: hazard/flush requests toward the controller and
// the stall vector, redirect and monitoring signals coming back.
interface pipe_ctrl_if #(
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
);
  logic              stallreq_from_id;
  logic              ex_mc_start;
  logic [CNT_W-1:0]  ex_mc_cycles;
  logic              flush_req;
  logic [31:0]       flush_pc_i;
  logic [5:0]        stall;
  logic              flush;
  logic [31:0]       new_pc_o;
  logic              ex_mc_done;
  logic              mc_busy;
  logic [CNT_W-1:0]  mc_cnt;
  logic [PERF_W-1:0] stall_cycles;
  logic              protocol_err;

  modport master (
    output stallreq_from_id, ex_mc_start, ex_mc_cycles, flush_req, flush_pc_i,
    input  stall, flush, new_pc_o, ex_mc_done, mc_busy, mc_cnt, stall_cycles,
           protocol_err
  );

  modport slave (
    input  stallreq_from_id, ex_mc_start, ex_mc_cycles, flush_req, flush_pc_i,
    output stall, flush, new_pc_o, ex_mc_done, mc_busy, mc_cnt, stall_cycles,
           protocol_err
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control: merges flush, multi-cycle EX occupancy and load-use
// stalls into the stall vector, with a registered flush pulse and stall counter.
module pipe_ctrl #(
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
) (
  input logic       clk,
  input logic       rst,
  pipe_ctrl_if.slave bus
);
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state;
  logic   start_ok;
  logic   long_op;

  // A start is not accepted in the cycle the previous flush pulse is visible.
  assign start_ok    = bus.ex_mc_start && !bus.flush;
  assign long_op     = bus.ex_mc_cycles >= CNT_W'(2);
  assign bus.mc_busy = (state == BUSY);

  always_comb begin
    bus.stall      = STALL_NONE;
    bus.ex_mc_done = 1'b0;
    if (!rst && !bus.flush_req) begin
      case (state)
        IDLE: begin
          if (start_ok && long_op) begin
            bus.stall = STALL_EX;
          end else begin
            bus.ex_mc_done = start_ok;
            bus.stall      = bus.stallreq_from_id ? STALL_ID : STALL_NONE;
          end
        end
        BUSY: begin
          if (bus.mc_cnt != '0) begin
            bus.stall = STALL_EX;
          end else begin
            bus.ex_mc_done = 1'b1;
            bus.stall      = bus.stallreq_from_id ? STALL_ID : STALL_NONE;
          end
        end
        default: bus.stall = STALL_NONE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      bus.mc_cnt       <= '0;
      bus.flush        <= 1'b0;
      bus.new_pc_o     <= '0;
      bus.stall_cycles <= '0;
      bus.protocol_err <= 1'b0;
    end else begin
      if (bus.stall != STALL_NONE && bus.stall_cycles != '1)
        bus.stall_cycles <= bus.stall_cycles + PERF_W'(1);

      bus.flush <= bus.flush_req;
      if (bus.flush_req) begin
        bus.new_pc_o <= bus.flush_pc_i;
        state        <= IDLE;
        bus.mc_cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_ok && long_op) begin
              // The start cycle and the done cycle both count toward N.
              bus.mc_cnt <= bus.ex_mc_cycles - CNT_W'(2);
              state      <= BUSY;
            end
          end
          BUSY: begin
            if (bus.ex_mc_start)
              bus.protocol_err <= 1'b1;
            if (bus.mc_cnt != '0)
              bus.mc_cnt <= bus.mc_cnt - CNT_W'(1);
            else
              state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed vector bench for pipe_ctrl, plus a saturation run on a narrow-counter copy.
module tb_pipe_ctrl;
  logic clk;
  logic rst;

  pipe_ctrl_if #(.CNT_W(6), .PERF_W(32)) bus ();
  pipe_ctrl_if #(.CNT_W(6), .PERF_W(4))  sat_bus ();

  pipe_ctrl #(.CNT_W(6), .PERF_W(32)) dut     (.clk(clk), .rst(rst), .bus(bus));
  pipe_ctrl #(.CNT_W(6), .PERF_W(4))  dut_sat (.clk(clk), .rst(rst), .bus(sat_bus));

  assign sat_bus.stallreq_from_id = bus.stallreq_from_id;
  assign sat_bus.ex_mc_start      = bus.ex_mc_start;
  assign sat_bus.ex_mc_cycles     = bus.ex_mc_cycles;
  assign sat_bus.flush_req        = bus.flush_req;
  assign sat_bus.flush_pc_i       = bus.flush_pc_i;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, id, start;
    logic [5:0]  n;
    logic        freq;
    logic [31:0] fpc;
    logic [5:0]  e_stall;
    logic        e_done, e_flush;
    logic [31:0] e_pc;
    logic        e_busy;
    logic [5:0]  e_cnt;
    logic [31:0] e_sc;
    logic        e_perr;
  } vec_t;

  vec_t vecs[$];
  int   nvec = 0;
  int   nerr = 0;

  function automatic vec_t mk(logic r, logic id, logic st, logic [5:0] n, logic fq,
                              logic [31:0] fpc, logic [5:0] es, logic ed, logic ef,
                              logic [31:0] ep, logic eb, logic [5:0] ec,
                              logic [31:0] esc, logic epe);
    vec_t v;
    v.rst = r; v.id = id; v.start = st; v.n = n; v.freq = fq; v.fpc = fpc;
    v.e_stall = es; v.e_done = ed; v.e_flush = ef; v.e_pc = ep; v.e_busy = eb;
    v.e_cnt = ec; v.e_sc = esc; v.e_perr = epe;
    return v;
  endfunction

  // Inputs change on the falling edge; everything is sampled 1 ns later.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst                  = v.rst;
    bus.stallreq_from_id = v.id;
    bus.ex_mc_start      = v.start;
    bus.ex_mc_cycles     = v.n;
    bus.flush_req        = v.freq;
    bus.flush_pc_i       = v.fpc;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  localparam logic [31:0] EPC = 32'hBFC00380;

  initial begin
    vec_t v;
    rst = 1'b1;
    bus.stallreq_from_id = 1'b1;
    bus.ex_mc_start      = 1'b1;
    bus.ex_mc_cycles     = 6'h3F;
    bus.flush_req        = 1'b1;
    bus.flush_pc_i       = 32'hFFFFFFFF;

    //          rst id st n  fq fpc           stall  dn fl pc             bz cnt sc perr
    vecs.push_back(mk(1, 1, 1, 63, 1, 32'hFFFFFFFF, 6'h00, 0, 0, 0,           0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,            6'h00, 0, 0, 0,           0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,            6'h00, 0, 0, 0,           0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,  0, 0,            6'h07, 0, 0, 0,           0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,            6'h00, 0, 0, 0,           0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 4,  0, 0,            6'h0F, 0, 0, 0,           0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,            6'h0F, 0, 0, 0,           1, 2, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,            6'h0F, 0, 0, 0,           1, 1, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,            6'h00, 1, 0, 0,           1, 0, 4, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,            6'h00, 0, 0, 0,           0, 0, 4, 0));
    vecs.push_back(mk(0, 0, 1, 1,  0, 0,            6'h00, 1, 0, 0,           0, 0, 4, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,            6'h00, 0, 0, 0,           0, 0, 4, 0));
    vecs.push_back(mk(0, 0, 1, 0,  0, 0,            6'h00, 1, 0, 0,           0, 0, 4, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,            6'h00, 0, 0, 0,           0, 0, 4, 0));
    vecs.push_back(mk(0, 0, 1, 8,  0, 0,            6'h0F, 0, 0, 0,           0, 0, 4, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,            6'h0F, 0, 0, 0,           1, 6, 5, 0));
    vecs.push_back(mk(0, 0, 0, 0,  1, EPC,          6'h00, 0, 0, 0,           1, 5, 6, 0));
    vecs.push_back(mk(0, 0, 1, 8,  0, 0,            6'h00, 0, 1, EPC,         0, 0, 6, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,            6'h00, 0, 0, EPC,         0, 0, 6, 0));
    vecs.push_back(mk(0, 1, 1, 3,  0, 0,            6'h0F, 0, 0, EPC,         0, 0, 6, 0));
    vecs.push_back(mk(0, 1, 1, 3,  0, 0,            6'h0F, 0, 0, EPC,         1, 1, 7, 0));
    vecs.push_back(mk(0, 1, 0, 0,  0, 0,            6'h07, 1, 0, EPC,         1, 0, 8, 1));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,            6'h00, 0, 0, EPC,         0, 0, 9, 1));
    vecs.push_back(mk(0, 1, 0, 0,  1, 32'h1234,     6'h00, 0, 0, EPC,         0, 0, 9, 1));
    vecs.push_back(mk(0, 0, 0, 0,  1, 32'h5678,     6'h00, 0, 1, 32'h1234,    0, 0, 9, 1));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,            6'h00, 0, 1, 32'h5678,    0, 0, 9, 1));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,            6'h00, 0, 0, 32'h5678,    0, 0, 9, 1));
    vecs.push_back(mk(1, 0, 0, 0,  0, 0,            6'h00, 0, 0, 32'h5678,    0, 0, 9, 1));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,            6'h00, 0, 0, 0,           0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 2,  0, 0,            6'h0F, 0, 0, 0,           0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,            6'h00, 1, 0, 0,           1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,            6'h00, 0, 0, 0,           0, 0, 1, 0));

    @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d stall", i),        32'(bus.stall),        32'(vecs[i].e_stall));
      checkOutput($sformatf("v%0d ex_mc_done", i),   32'(bus.ex_mc_done),   32'(vecs[i].e_done));
      checkOutput($sformatf("v%0d flush", i),        32'(bus.flush),        32'(vecs[i].e_flush));
      checkOutput($sformatf("v%0d new_pc_o", i),     bus.new_pc_o,          vecs[i].e_pc);
      checkOutput($sformatf("v%0d mc_busy", i),      32'(bus.mc_busy),      32'(vecs[i].e_busy));
      checkOutput($sformatf("v%0d mc_cnt", i),       32'(bus.mc_cnt),       32'(vecs[i].e_cnt));
      checkOutput($sformatf("v%0d stall_cycles", i), bus.stall_cycles,      vecs[i].e_sc);
      checkOutput($sformatf("v%0d protocol_err", i), 32'(bus.protocol_err), 32'(vecs[i].e_perr));
    end

    // Saturation: hold a load-use stall for 20 cycles after a fresh reset.
    v = mk(1, 0, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(v);
    for (int k = 0; k <= 20; k++) begin
      v = mk(0, (k < 20), 0, 0, 0, 0, 6'h00, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(v);
      checkOutput($sformatf("sat%0d stall", k), 32'(bus.stall), (k < 20) ? 32'h07 : 32'h00);
      checkOutput($sformatf("sat%0d stall_cycles", k), bus.stall_cycles, 32'(k));
      checkOutput($sformatf("sat%0d stall_cycles_w4", k), 32'(sat_bus.stall_cycles),
                  (k > 15) ? 32'hF : 32'(k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline control unit for the five-stage core. It merges the decode-stage load-use stall request, a multi-cycle execute-op sequencer and the flush request into the 6-bit stall vector (bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB) and a registered flush/new-PC pulse. It also counts stall cycles for performance monitoring.

Parameters:
CNT_W, 6, width of the multi-cycle length input and the internal down-counter
PERF_W, 32, width of the saturating stall-cycle counter

Ports:
clk  input  1  core clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset (`RstEnable = 1'b1)
stallreq_from_id  input  1  decode load-use hazard; stall PC/IF/ID this cycle
ex_mc_start  input  1  EX begins a multi-cycle op this cycle
ex_mc_cycles  input  CNT_W  total EX occupancy N of that op, sampled with ex_mc_start
flush_req  input  1  exception or redirect; abort in-flight work
flush_pc_i  input  32  redirect target, sampled with flush_req
stall  output  6  stall vector, combinational from state and inputs
flush  output  1  registered one-cycle flush pulse
new_pc_o  output  32  registered redirect PC, valid when flush=1
ex_mc_done  output  1  last EX cycle of a multi-cycle op; result is valid
mc_busy  output  1  state==BUSY
mc_cnt  output  CNT_W  remaining stall cycles in BUSY
stall_cycles  output  PERF_W  saturating count of cycles with stall!=0
protocol_err  output  1  sticky; ex_mc_start seen while BUSY

Behaviour:
- Reset (rst=1 at clock edge): state IDLE, mc_cnt=0, flush=0, new_pc_o=0, stall_cycles=0, protocol_err=0. While rst=1, the combinational outputs are forced: stall=6'b000000, ex_mc_done=0.
- Stall encodings: none 6'b000000; ID request 6'b000111; EX busy 6'b001111.
- Priority each cycle: flush_req > EX multi-cycle > stallreq_from_id.
- States: IDLE, BUSY.
- IDLE, flush_req=0:
  - ex_mc_start=1 and N>=2: stall=001111, mc_cnt<=N-2, next BUSY.
  - ex_mc_start=1 and N<=1: no stall from EX, ex_mc_done=1 this cycle, stay IDLE.
  - otherwise: stall=000111 if stallreq_from_id, else 000000.
- BUSY, flush_req=0:
  - mc_cnt!=0: stall=001111, mc_cnt<=mc_cnt-1.
  - mc_cnt==0: ex_mc_done=1, EX stall released, stall=000111 if stallreq_from_id else 000000, next IDLE.
  - ex_mc_start=1 in BUSY is ignored and sets protocol_err<=1.
- Timing result: an N-cycle op (N>=2) occupies EX for exactly N cycles and stalls the pipe for N-1 cycles.
- flush_req=1 (any state):
  - stall=000000 and ex_mc_done=0 that cycle.
  - next state IDLE, mc_cnt<=0.
  - flush<=1 and new_pc_o<=flush_pc_i, so the flush pulse appears the following cycle.
  - ex_mc_start is ignored both in the flush_req cycle and in the cycle flush=1.
- flush deasserts after one cycle unless flush_req is held. new_pc_o holds its last value.
- stall_cycles increments on every non-reset cycle with stall!=0 and saturates at all-ones.
- protocol_err is cleared only by rst.

Test Plan:
- Reset: hold rst 2 cycles with all inputs 1 -> stall=0, flush=0, stall_cycles=0, protocol_err=0; after release with inputs idle, all outputs stay 0.
- Load-use: stallreq_from_id=1 for 1 cycle in IDLE -> stall=6'b000111 that same cycle only; stall_cycles=1.
- Multi-cycle N=4 at cycle t -> stall=001111 at t, t+1, t+2; ex_mc_done=1 at t+3 with stall=0; mc_cnt 2,1,0; stall_cycles=3. N=1 -> ex_mc_done=1 at t, no stall. N=0 -> same as N=1.
- Flush mid-op: N=8 started at t, flush_req=1 with flush_pc_i=32'hBFC00380 at t+2 -> stall=0 at t+2, flush=1 and new_pc_o=32'hBFC00380 at t+3, mc_busy=0, ex_mc_done never asserts; ex_mc_start at t+3 is ignored.
- Overlap: stallreq_from_id=1 throughout an N=3 op -> stall=001111 for 2 cycles, then 000111 in the done cycle; ex_mc_start pulsed at t+1 -> protocol_err=1 and stays 1 until rst.
- Saturation: with PERF_W=4, hold stall 20 cycles -> stall_cycles stops at 4'hF.
